// File: rtl/step_move_if.sv
// Command/status bundle between the host-side logic and step_move_controller.
// With STEP_POS_TRACK_EN defined it also carries pos_clear and position.
interface step_move_if #(
  parameter int STEP_W   = 16,
  parameter int PERIOD_W = 20
`ifdef STEP_POS_TRACK_EN
  ,
  parameter int POS_W    = 24
`endif
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [STEP_W-1:0]   cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;
  logic                abort;
  logic                step_enable;
  logic                step_direction;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [STEP_W-1:0]   steps_left;
`ifdef STEP_POS_TRACK_EN
  logic                      pos_clear;
  logic signed [POS_W-1:0]   position;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort, pos_clear,
    input  cmd_ready, step_enable, step_direction, busy, done, aborted,
           steps_left, position
  );
  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, abort, pos_clear,
    output cmd_ready, step_enable, step_direction, busy, done, aborted,
           steps_left, position
  );
`else
  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
    input  cmd_ready, step_enable, step_direction, busy, done, aborted,
           steps_left
  );
  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
    output cmd_ready, step_enable, step_direction, busy, done, aborted,
           steps_left
  );
`endif
endinterface

// File: rtl/step_move_controller.sv
// Step move sequencer: accepts a move command (direction, step count, period)
// and issues evenly spaced one-cycle step pulses to the phase FSM, then a
// one-cycle done. Optional macro STEP_POS_TRACK_EN adds a signed position
// counter with a synchronous clear.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | timer counting down, pulse when timer reaches 0
// DONE  | single-cycle completion (normal end or abort)
module step_move_controller #(
  parameter int STEP_W   = 16,
  parameter int PERIOD_W = 20
`ifdef STEP_POS_TRACK_EN
  ,
  parameter int POS_W    = 24
`endif
) (
  input  logic      clock,
  input  logic      reset,
  step_move_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] reload_q, reload_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                dir_q, dir_d;
  logic                aborted_q, aborted_d;
  logic [PERIOD_W-1:0] period_m1;

  // A zero period behaves like a period of one (back-to-back pulses).
  assign period_m1 = (bus.cmd_period == '0) ? '0 : bus.cmd_period - PERIOD_W'(1);

  // All outputs decode from registered state only.
  assign bus.cmd_ready      = (state_q == IDLE);
  assign bus.step_enable    = (state_q == RUN) && (timer_q == '0);
  assign bus.step_direction = dir_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = (state_q == DONE);
  assign bus.aborted        = aborted_q;
  assign bus.steps_left     = steps_q;

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      reload_q  <= '0;
      steps_q   <= '0;
      dir_q     <= 1'b1;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      reload_q  <= reload_d;
      steps_q   <= steps_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    reload_d  = reload_q;
    steps_d   = steps_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          dir_d     = bus.cmd_dir;
          steps_d   = bus.cmd_steps;
          reload_d  = period_m1;
          timer_d   = period_m1;
          aborted_d = 1'b0;
          state_d   = (bus.cmd_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (timer_q == '0) begin
          steps_d = steps_q - STEP_W'(1);
          timer_d = reload_q;
          if (steps_q == STEP_W'(1)) state_d = DONE;
        end else begin
          timer_d = timer_q - PERIOD_W'(1);
        end
        // The pulse of this cycle (if any) is already counted above.
        if (bus.abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef STEP_POS_TRACK_EN
  logic signed [POS_W-1:0] position_q;

  assign bus.position = position_q;

  // Position follows every step pulse; a clear in the same cycle wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      position_q <= '0;
    end else if (bus.pos_clear) begin
      position_q <= '0;
    end else if (bus.step_enable) begin
      position_q <= dir_q ? position_q + POS_W'(1) : position_q - POS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_step_move_controller.sv
// Bench for step_move_controller: directed moves plus random moves, each
// compared cycle by cycle with expectations computed from the pulse timing
// rule (pulse k in RUN cycle k*P-1, done in cycle N*P or after abort).
module tb_step_move_controller;
  localparam int STEP_W   = 16;
  localparam int PERIOD_W = 20;
  localparam int POS_W    = 24;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  bit   rand_clr = 1'b1;
  logic signed [POS_W-1:0] model_pos = '0;

`ifdef STEP_POS_TRACK_EN
  step_move_if #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W), .POS_W(POS_W)) bus ();
  step_move_controller #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W), .POS_W(POS_W)) dut (
    .clock(clock), .reset(reset), .bus(bus));
`else
  step_move_if #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W)) bus ();
  step_move_controller #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W)) dut (
    .clock(clock), .reset(reset), .bus(bus));
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Check position, then choose pos_clear for this cycle and advance the model.
  task automatic pos_cycle(input bit pulse, input bit d);
`ifdef STEP_POS_TRACK_EN
    bit pc;
    chk("position", 32'(bus.position), 32'(model_pos));
    pc = rand_clr && ($urandom_range(0, 7) == 0);
    bus.pos_clear = pc;
    if (pc) model_pos = '0;
    else if (pulse) model_pos = d ? model_pos + 1'b1 : model_pos - 1'b1;
`else
    if (pulse && d) model_pos = model_pos;
`endif
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_step", bus.step_enable, 0);
    chk("rst_dir", bus.step_direction, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_aborted", bus.aborted, 0);
    chk("rst_left", 32'(bus.steps_left), 0);
  endtask

  // One complete move starting at a negedge in IDLE; ends at the negedge of
  // the first IDLE cycle after done. With hold set, cmd_valid stays high and
  // the next command (nd/nn/np) is presented throughout the move.
  task automatic run_move(input bit d, input int n, input int praw, input int ab_at,
                          input bit hold, input bit nd, input int nn, input int np);
    int p, end_c, exp_left;
    bit ab;
    p        = (praw == 0) ? 1 : praw;
    ab       = (ab_at >= 0) && (ab_at < n * p);
    end_c    = ab ? ab_at + 1 : n * p;
    exp_left = ab ? n - (ab_at + 1) / p : 0;

    chk("idle_ready", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_dir    = d;
    bus.cmd_steps  = STEP_W'(n);
    bus.cmd_period = PERIOD_W'(praw);
    pos_cycle(1'b0, d);
    @(negedge clock);
    if (hold) begin
      bus.cmd_dir    = nd;
      bus.cmd_steps  = STEP_W'(nn);
      bus.cmd_period = PERIOD_W'(np);
    end else begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_dir    = 1'($urandom);
      bus.cmd_steps  = STEP_W'($urandom);
      bus.cmd_period = PERIOD_W'($urandom);
    end

    for (int c = 0; c < end_c; c++) begin
      chk("run_step", bus.step_enable, 32'(((c + 1) % p) == 0));
      chk("run_left", 32'(bus.steps_left), 32'(n - c / p));
      chk("run_busy", bus.busy, 1);
      chk("run_done", bus.done, 0);
      chk("run_ready", bus.cmd_ready, 0);
      chk("run_dir", bus.step_direction, 32'(d));
      chk("run_aborted", bus.aborted, 0);
      pos_cycle(((c + 1) % p) == 0, d);
      bus.abort = (c == ab_at);
      @(negedge clock);
    end

    bus.abort = 1'($urandom);
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 1);
    chk("done_ready", bus.cmd_ready, 0);
    chk("done_step", bus.step_enable, 0);
    chk("done_left", 32'(bus.steps_left), 32'(exp_left));
    chk("done_aborted", bus.aborted, 32'(ab));
    chk("done_dir", bus.step_direction, 32'(d));
    pos_cycle(1'b0, d);
    @(negedge clock);

    bus.abort = 1'($urandom);
    chk("idle_done", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_left", 32'(bus.steps_left), 32'(exp_left));
    chk("idle_aborted", bus.aborted, 32'(ab));
    chk("idle_dir", bus.step_direction, 32'(d));
  endtask

  initial begin
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_dir    = 1'b0;
    bus.cmd_steps  = '0;
    bus.cmd_period = '0;
    bus.abort      = 1'b0;
`ifdef STEP_POS_TRACK_EN
    bus.pos_clear  = 1'b0;
`endif
    #1;
    chk_reset_vals();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals();

    // Directed moves from the timing rule.
    run_move(1'b1, 4, 3, -1, 1'b0, 1'b0, 0, 0);
    run_move(1'b0, 3, 0, -1, 1'b0, 1'b0, 0, 0);
    run_move(1'b1, 0, 5, -1, 1'b0, 1'b0, 0, 0);
    run_move(1'b1, 10, 4, 7, 1'b0, 1'b0, 0, 0);
    run_move(1'b0, 2, 2, -1, 1'b0, 1'b0, 0, 0);
    // Command held valid during the move: next one accepted only from IDLE.
    run_move(1'b1, 3, 2, -1, 1'b1, 1'b0, 2, 3);
    run_move(1'b0, 2, 3, -1, 1'b0, 1'b0, 0, 0);
    // Abort in a non-pulse cycle and in cycle 0.
    run_move(1'b1, 5, 3, 4, 1'b0, 1'b0, 0, 0);
    run_move(1'b0, 4, 1, 0, 1'b0, 1'b0, 0, 0);

    // Random moves.
    for (int i = 0; i < 12; i++) begin
      int n, p, ab_at;
      n     = $urandom_range(0, 6);
      p     = $urandom_range(0, 4);
      ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 24)) : -1;
      run_move(1'($urandom), n, p, ab_at, 1'b0, 1'b0, 0, 0);
    end

    // Reset in the middle of a long reverse move after five pulses.
    bus.abort      = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_dir    = 1'b0;
    bus.cmd_steps  = STEP_W'(100);
    bus.cmd_period = PERIOD_W'(2);
    pos_cycle(1'b0, 1'b0);
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      pos_cycle(((c + 1) % 2) == 0, 1'b0);
      @(negedge clock);
    end
    chk("mid_left", 32'(bus.steps_left), 95);
    chk("mid_dir", bus.step_direction, 0);
    #2;
    reset = 1'b1;
    model_pos = '0;
    #1;
    chk_reset_vals();
    pos_cycle(1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_step", bus.step_enable, 0);
      pos_cycle(1'b0, 1'b0);
      @(negedge clock);
    end

    rand_clr = 1'b0;
`ifdef STEP_POS_TRACK_EN
    bus.pos_clear = 1'b1;
    model_pos = '0;
    @(negedge clock);
`endif
    run_move(1'b0, 3, 1, -1, 1'b0, 1'b0, 0, 0);
`ifdef STEP_POS_TRACK_EN
    chk("pos_minus3", 32'(bus.position), 32'(-3));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/step_move_controller.md
Name: step_move_controller

Overview:
Command sequencer that drives the stepper phase FSM's enable/direction inputs. Accepts a move command (direction, step count, step period) over a valid/ready handshake. Issues exactly the commanded number of one-cycle step pulses, evenly spaced, then signals completion. Sits between the host/button logic and the phase-sequencing FSM, whose enable it owns exclusively.

Parameters:
STEP_W, 16, width of step count and steps_left
PERIOD_W, 20, width of step period in clock cycles
POS_W, 24, width of signed position counter (optional feature only)

Ports:
clock  input  1  system clock
reset  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command (IDLE only)
cmd_dir  input  1  1 = forward, 0 = reverse
cmd_steps  input  STEP_W  number of steps to issue
cmd_period  input  PERIOD_W  clock cycles between step pulses; 0 treated as 1
abort  input  1  stop current move after the current cycle
step_enable  output  1  one-cycle step pulse to phase FSM enable
step_direction  output  1  direction to phase FSM, stable for whole move
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse at move end
aborted  output  1  last move ended by abort; held until next accept
steps_left  output  STEP_W  remaining steps of current move

Behaviour:
- States: IDLE, RUN, DONE. Reset: IDLE; cmd_ready=1, step_enable=0, step_direction=1, busy=0, done=0, aborted=0, steps_left=0, internal timer=0.
- All outputs decode from registered state only; no combinational input-to-output path (cmd_ready = state==IDLE).
- IDLE: accept on cmd_valid && cmd_ready at edge. Latch step_direction=cmd_dir, steps_left=cmd_steps, P=max(cmd_period,1), timer=P-1, clear aborted.
  - cmd_steps==0 -> DONE directly (no pulses).
  - else -> RUN.
- RUN: step_enable = (timer==0).
  - timer!=0: timer decrements.
  - timer==0: steps_left decrements and timer reloads P-1. If steps_left was 1, go to DONE.
  - Counting the first RUN cycle as cycle 0, pulse k (k=1..N) occurs in cycle k*P-1, and done is high in cycle N*P.
  - P=1 gives back-to-back pulses every cycle.
- abort sampled high in RUN:
  - The pulse for that cycle still fires if timer==0, and its step is counted.
  - Next state is DONE; aborted is set; steps_left holds the remaining count.
  - abort in IDLE or DONE is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in DONE, so commands are never accepted on the done cycle.
- step_direction holds its last latched value in IDLE/DONE. It changes only at acceptance.
- Reset mid-move: immediate return to reset values, with no pulse and no done.
- cmd_* inputs are ignored outside the acceptance edge.

Optional Feature:
STEP_POS_TRACK_EN:
- Defined:
  - Adds output position [POS_W-1:0], signed, reset 0.
  - Adds input pos_clear (synchronous, 1 bit).
  - On each step_enable, position changes by +1 if step_direction=1, else by -1. Wraps modulo 2^POS_W.
  - If pos_clear is high in the same cycle as a step, the result is 0; pos_clear wins.
- Undefined: no position port, no pos_clear port, no counter logic.

Test Plan:
- Reset, then cmd steps=4, period=3, dir=1 -> step_enable in RUN cycles 2,5,8,11; done in cycle 12; step_direction=1 throughout; steps_left 4→0.
- cmd steps=3, period=0 -> treated as P=1; pulses in cycles 0,1,2; done in cycle 3; busy high for 4 cycles.
- cmd steps=0, period=5 -> no step_enable; done one cycle after accept; aborted=0.
- cmd steps=10, period=4, abort in RUN cycle 7 (a pulse cycle) -> pulses at 3,7 only; steps_left=8; DONE next; aborted=1; cleared on next accept.
- cmd_valid held high during RUN/DONE with a new command -> not accepted until IDLE; second move begins one cycle after done with new direction.
- Reset asserted mid-move (steps=100, P=2, after 5 pulses) -> outputs return to reset values; no done. With STEP_POS_TRACK_EN, position=0 after reset; a subsequent dir=0 steps=3 move gives position=-3.
